// File: rtl/ben_unit.sv
// ben_unit: LC-3 branch-enable stage; latches IR/PC/nzp, computes BEN and PC+SEXT(offset). Optional BEN_STATS_EN counters.
// Latency: request sampled on LD_BEN at one edge, result (br_valid, BEN, br_target) presented after the next edge.
// Backpressure: result held with br_valid high until br_ack; LD_BEN is dropped whenever br_busy is high.
module ben_unit #(
    parameter int WIDTH    = 16,
    parameter int OFFSET_W = 9
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] IR,
    input  logic [WIDTH-1:0] PC,
    input  logic [WIDTH-1:0] nzp,
    input  logic             LD_BEN,
    input  logic             br_ack,
    output logic             BEN,
    output logic [WIDTH-1:0] br_target,
    output logic             br_valid,
    output logic             br_busy,
    output logic [15:0]      eval_cnt,
    output logic [15:0]      taken_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] cap_ir;
    logic [WIDTH-1:0] cap_pc;
    logic [2:0]       cap_nzp;

    logic             new_ben;
    logic [WIDTH-1:0] new_target;
    logic [WIDTH-1:0] offset_sext;

    // Opcode bits and the upper condition-code bits are deliberately not decoded here.
    logic unused_bits;
    assign unused_bits = ^{nzp[WIDTH-1:3], cap_ir[WIDTH-1:12]};

    assign offset_sext = {{(WIDTH-OFFSET_W){cap_ir[OFFSET_W-1]}}, cap_ir[OFFSET_W-1:0]};
    assign new_ben     = |(cap_ir[11:9] & cap_nzp);
    assign new_target  = cap_pc + offset_sext;

    assign br_busy  = (state != IDLE);
    assign br_valid = (state == RESP);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            cap_ir    <= '0;
            cap_pc    <= '0;
            cap_nzp   <= '0;
            BEN       <= 1'b0;
            br_target <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (LD_BEN) begin
                        cap_ir  <= IR;
                        cap_pc  <= PC;
                        cap_nzp <= nzp[2:0];
                        state   <= EVAL;
                    end
                end
                EVAL: begin
                    BEN       <= new_ben;
                    br_target <= new_target;
                    state     <= RESP;
                end
                RESP: begin
                    if (br_ack) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BEN_STATS_EN
    // Counters advance on the EVAL->RESP transition and stick at all-ones.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            eval_cnt  <= 16'h0000;
            taken_cnt <= 16'h0000;
        end else if (state == EVAL) begin
            if (eval_cnt != 16'hFFFF) begin
                eval_cnt <= eval_cnt + 16'd1;
            end
            if (new_ben && (taken_cnt != 16'hFFFF)) begin
                taken_cnt <= taken_cnt + 16'd1;
            end
        end
    end
`else
    assign eval_cnt  = 16'h0000;
    assign taken_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_ben_unit.sv
// Scoreboard bench for ben_unit: stimulus pushes model results, a negedge monitor pops and compares.
module tb_ben_unit;

`ifdef BEN_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic [15:0] IR = '0, PC = '0, nzp = '0;
    logic        LD_BEN = 1'b0, br_ack = 1'b0;
    logic        BEN, br_valid, br_busy;
    logic [15:0] br_target, eval_cnt, taken_cnt;

    ben_unit dut (
        .Clk(Clk), .Reset(Reset), .IR(IR), .PC(PC), .nzp(nzp),
        .LD_BEN(LD_BEN), .br_ack(br_ack), .BEN(BEN), .br_target(br_target),
        .br_valid(br_valid), .br_busy(br_busy), .eval_cnt(eval_cnt), .taken_cnt(taken_cnt)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        ben;
        logic [15:0] tgt;
        int          cyc;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   exp_eval = 0;
    int   exp_taken = 0;
    bit   prev_valid = 1'b0;

    always @(posedge Clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Reference: branch taken if any requested flag is set; target is PC plus signed 9-bit offset mod 2^16.
    function automatic exp_t model(input logic [15:0] ir, input logic [15:0] pc,
                                   input logic [15:0] nz, input int c);
        exp_t m;
        int   off;
        int   t;
        off = int'(ir[8:0]);
        if (off >= 256) off = off - 512;
        t = int'(pc) + off;
        m.tgt = t[15:0];
        m.ben = (ir[11] && nz[2]) || (ir[10] && nz[1]) || (ir[9] && nz[0]);
        m.cyc = c;
        return m;
    endfunction

    function automatic int sat_inc(input int v);
        return (v + 1 > 65535) ? 65535 : v + 1;
    endfunction

    task automatic chk_counts();
        chk("eval_cnt", {16'h0, eval_cnt}, STATS ? exp_eval : 0);
        chk("taken_cnt", {16'h0, taken_cnt}, STATS ? exp_taken : 0);
    endtask

    task automatic do_req(input logic [15:0] ir, input logic [15:0] pc, input logic [15:0] nz,
                          input int ack_dly, input bit junk);
        exp_t e;
        IR = ir; PC = pc; nzp = nz; LD_BEN = 1'b1;
        e = model(ir, pc, nz, cyc + 2);
        q.push_back(e);
        step();
        chk("busy_eval", {31'h0, br_busy}, 1);
        LD_BEN = junk;
        if (junk) begin
            IR = 16'h0E10; PC = 16'($urandom); nzp = 16'h0007;
        end
        step();
        LD_BEN = 1'b0;
        exp_eval = sat_inc(exp_eval);
        if (e.ben) exp_taken = sat_inc(exp_taken);
        repeat (ack_dly) step();
        br_ack = 1'b1;
        LD_BEN = junk;
        step();
        br_ack = 1'b0;
        LD_BEN = 1'b0;
        chk("idle_busy", {31'h0, br_busy}, 0);
        chk("idle_valid", {31'h0, br_valid}, 0);
        chk("held_ben", {31'h0, BEN}, {31'h0, e.ben});
        chk("held_target", {16'h0, br_target}, {16'h0, e.tgt});
        chk_counts();
    endtask

    always @(negedge Clk) begin
        if (br_valid) begin
            if (!prev_valid) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_valid actual=1 required=0 (cycle %0d)", cyc);
                end else begin
                    cur = q.pop_front();
                    chk("latency", cyc, cur.cyc);
                    chk("ben", {31'h0, BEN}, {31'h0, cur.ben});
                    chk("target", {16'h0, br_target}, {16'h0, cur.tgt});
                end
            end else begin
                chk("hold_ben", {31'h0, BEN}, {31'h0, cur.ben});
                chk("hold_target", {16'h0, br_target}, {16'h0, cur.tgt});
            end
        end
        prev_valid = br_valid;
    end

    initial begin
        // Reset with a request pending: reset must win.
        Reset = 1'b1; LD_BEN = 1'b1; IR = 16'h0E05; PC = 16'h1111; nzp = 16'h0004;
        step();
        step();
        Reset = 1'b0; LD_BEN = 1'b0;
        chk("rst_ben", {31'h0, BEN}, 0);
        chk("rst_target", {16'h0, br_target}, 0);
        chk("rst_valid", {31'h0, br_valid}, 0);
        chk("rst_busy", {31'h0, br_busy}, 0);
        chk_counts();

        do_req(16'h0805, 16'h3001, 16'h0004, 5, 1'b0);
        do_req(16'h0BFF, 16'h0000, 16'h0002, 1, 1'b0);
        do_req(16'h0805, 16'h3001, 16'h0004, 2, 1'b1);

        // Reset while evaluating: nothing emerges and no count is recorded.
        IR = 16'h0E01; PC = 16'h2000; nzp = 16'h0001; LD_BEN = 1'b1;
        step();
        LD_BEN = 1'b0;
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        exp_eval = 0;
        exp_taken = 0;
        chk("mid_rst_valid", {31'h0, br_valid}, 0);
        chk("mid_rst_busy", {31'h0, br_busy}, 0);
        chk("mid_rst_ben", {31'h0, BEN}, 0);
        chk("mid_rst_target", {16'h0, br_target}, 0);
        chk_counts();

        do_req(16'h0E00, 16'h0100, 16'h0008, 0, 1'b0);
        do_req(16'h0F00, 16'hFFFF, 16'h0001, 0, 1'b0);
        do_req(16'h0100, 16'h8000, 16'h0007, 3, 1'b0);

        for (int i = 0; i < 24; i++) begin
            do_req(16'($urandom), 16'($urandom), 16'($urandom),
                   int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
        end

`ifdef BEN_STATS_EN
        force dut.eval_cnt = 16'hFFFF;
        force dut.taken_cnt = 16'hFFFF;
        step();
        release dut.eval_cnt;
        release dut.taken_cnt;
        exp_eval = 65535;
        exp_taken = 65535;
        do_req(16'h0E00, 16'h1234, 16'h0001, 0, 1'b0);
        do_req(16'h0000, 16'h1234, 16'h0001, 0, 1'b0);
`endif

        repeat (4) step();
        chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
